// File: rtl/cr_axis_frame_tagger.sv
// cr_axis_frame_tagger: single register stage on an AXI-stream path.
// Frames are tracked per channel (tid). A trailer beat gets m_tlast when a CQE header was
// seen on its channel, and gets m_tstats when a stats header was seen on its channel.
// Data beats (tuser=3) leave with tuser=0. Each beat carries its 1-based index within the
// frame. A frame_done pulse reports every frame that completes on the m side. A watchdog
// flags a stretch with no m-side traffic.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   s_t*                          upstream AXI-stream slave (tvalid/tready/tid/tdata/tstrb/tuser)
//   m_t*                          downstream AXI-stream master, plus tlast/tstats/tbeats tags
//   wdog_en/limit/clr, wdog_expired   no-traffic watchdog control and sticky flag
//   frame_done, frame_done_tid/beats  pulse, channel and beat count per completed frame
module cr_axis_frame_tagger #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned USER_W     = 8,
  parameter int unsigned TID_W      = 2,
  parameter logic [7:0]  CQE_CODE   = 8'h09,
  parameter logic [7:0]  STATS_CODE = 8'h08,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WDOG_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [TID_W-1:0]      s_tid,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic [DATA_W/8-1:0]   s_tstrb,
  input  logic [USER_W-1:0]     s_tuser,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [TID_W-1:0]      m_tid,
  output logic [DATA_W-1:0]     m_tdata,
  output logic [DATA_W/8-1:0]   m_tstrb,
  output logic [USER_W-1:0]     m_tuser,
  output logic                  m_tlast,
  output logic                  m_tstats,
  output logic [CNT_W-1:0]      m_tbeats,
  input  logic                  wdog_en,
  input  logic [WDOG_W-1:0]     wdog_limit,
  input  logic                  wdog_clr,
  output logic                  wdog_expired,
  output logic                  frame_done,
  output logic [TID_W-1:0]      frame_done_tid,
  output logic [CNT_W-1:0]      frame_done_beats
);

  localparam int unsigned NumCh = 2 ** TID_W;

  // Output register stage
  logic                m_tvalid_q;
  logic [TID_W-1:0]    m_tid_q;
  logic [DATA_W-1:0]   m_tdata_q;
  logic [DATA_W/8-1:0] m_tstrb_q;
  logic [USER_W-1:0]   m_tuser_q;
  logic                m_tlast_q;
  logic                m_tstats_q;
  logic [CNT_W-1:0]    m_tbeats_q;

  // Per-channel framing state
  logic [NumCh-1:0]    cqe_q, cqe_d;
  logic [NumCh-1:0]    stats_q, stats_d;
  logic [CNT_W-1:0]    cnt_q [NumCh];
  logic [CNT_W-1:0]    cnt_d [NumCh];

  // Completion report and watchdog
  logic                fd_q;
  logic [TID_W-1:0]    fd_tid_q;
  logic [CNT_W-1:0]    fd_beats_q;
  logic [WDOG_W-1:0]   wcnt_q, wcnt_d;
  logic                wdog_q, wdog_d;

  logic                accept;
  logic                m_hs;
  logic                is_hdr, is_trl, is_data;
  logic                cur_cqe, cur_stats;
  logic [CNT_W-1:0]    cur_cnt, beats;
  logic                tag_last, tag_stats;
  logic [USER_W-1:0]   user_out;

  assign s_tready = !m_tvalid_q || m_tready;
  assign accept   = s_tvalid && s_tready;
  assign m_hs     = m_tvalid_q && m_tready;

  // Decode the incoming beat against its own channel's state
  always_comb begin
    is_hdr    = (s_tuser == USER_W'(1));
    is_trl    = (s_tuser == USER_W'(2));
    is_data   = (s_tuser == USER_W'(3));
    cur_cqe   = cqe_q[s_tid];
    cur_stats = stats_q[s_tid];
    cur_cnt   = cnt_q[s_tid];
    beats     = (&cur_cnt) ? cur_cnt : cur_cnt + CNT_W'(1);
    tag_last  = is_trl && cur_cqe;
    tag_stats = is_trl && cur_stats;
    user_out  = is_data ? '0 : s_tuser;
  end

  always_comb begin
    cqe_d   = cqe_q;
    stats_d = stats_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (is_hdr && (s_tdata[7:0] == CQE_CODE))   cqe_d[s_tid]   = 1'b1;
      if (is_hdr && (s_tdata[7:0] == STATS_CODE)) stats_d[s_tid] = 1'b1;
      if (is_trl) begin
        cqe_d[s_tid]   = 1'b0;
        stats_d[s_tid] = 1'b0;
      end
      // Only a tlast-tagged trailer closes the frame; untagged trailers keep counting.
      cnt_d[s_tid] = tag_last ? '0 : beats;
    end
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (m_hs || !wdog_en) begin
      wcnt_d = '0;
    end else if (!(&wcnt_q)) begin
      wcnt_d = wcnt_q + WDOG_W'(1);
    end
    wdog_d = wdog_q;
    // Compare the count including this cycle so expiry lands on the cycle the limit is hit.
    if (wdog_en && (wdog_limit != '0) && (wcnt_d >= wdog_limit)) wdog_d = 1'b1;
    if (wdog_clr) wdog_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_tvalid_q <= 1'b0;
      m_tid_q    <= '0;
      m_tdata_q  <= '0;
      m_tstrb_q  <= '0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tstats_q <= 1'b0;
      m_tbeats_q <= '0;
      cqe_q      <= '0;
      stats_q    <= '0;
      for (int i = 0; i < NumCh; i++) cnt_q[i] <= '0;
      fd_q       <= 1'b0;
      fd_tid_q   <= '0;
      fd_beats_q <= '0;
      wcnt_q     <= '0;
      wdog_q     <= 1'b0;
    end else begin
      if (accept) begin
        m_tvalid_q <= 1'b1;
        m_tid_q    <= s_tid;
        m_tdata_q  <= s_tdata;
        m_tstrb_q  <= s_tstrb;
        m_tuser_q  <= user_out;
        m_tlast_q  <= tag_last;
        m_tstats_q <= tag_stats;
        m_tbeats_q <= beats;
      end else if (m_tready) begin
        m_tvalid_q <= 1'b0;
      end
      cqe_q   <= cqe_d;
      stats_q <= stats_d;
      cnt_q   <= cnt_d;
      fd_q    <= m_hs && m_tlast_q;
      if (m_hs && m_tlast_q) begin
        fd_tid_q   <= m_tid_q;
        fd_beats_q <= m_tbeats_q;
      end
      wcnt_q <= wcnt_d;
      wdog_q <= wdog_d;
    end
  end

  assign m_tvalid         = m_tvalid_q;
  assign m_tid            = m_tid_q;
  assign m_tdata          = m_tdata_q;
  assign m_tstrb          = m_tstrb_q;
  assign m_tuser          = m_tuser_q;
  assign m_tlast          = m_tlast_q;
  assign m_tstats         = m_tstats_q;
  assign m_tbeats         = m_tbeats_q;
  assign wdog_expired     = wdog_q;
  assign frame_done       = fd_q;
  assign frame_done_tid   = fd_tid_q;
  assign frame_done_beats = fd_beats_q;

endmodule

// File: tb/tb_cr_axis_frame_tagger.sv
// Directed bench for cr_axis_frame_tagger: per-scenario tasks with inline expected values.
module tb_cr_axis_frame_tagger;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [1:0]  s_tid = '0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tstrb = '0;
  logic [7:0]  s_tuser = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [1:0]  m_tid;
  logic [63:0] m_tdata;
  logic [7:0]  m_tstrb;
  logic [7:0]  m_tuser;
  logic        m_tlast;
  logic        m_tstats;
  logic [15:0] m_tbeats;
  logic        wdog_en = 1'b0;
  logic [15:0] wdog_limit = '0;
  logic        wdog_clr = 1'b0;
  logic        wdog_expired;
  logic        frame_done;
  logic [1:0]  frame_done_tid;
  logic [15:0] frame_done_beats;

  int total = 0;
  int bad = 0;
  bit rnd_rdy = 1'b0;

  cr_axis_frame_tagger dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_tvalid         (s_tvalid),
    .s_tready         (s_tready),
    .s_tid            (s_tid),
    .s_tdata          (s_tdata),
    .s_tstrb          (s_tstrb),
    .s_tuser          (s_tuser),
    .m_tvalid         (m_tvalid),
    .m_tready         (m_tready),
    .m_tid            (m_tid),
    .m_tdata          (m_tdata),
    .m_tstrb          (m_tstrb),
    .m_tuser          (m_tuser),
    .m_tlast          (m_tlast),
    .m_tstats         (m_tstats),
    .m_tbeats         (m_tbeats),
    .wdog_en          (wdog_en),
    .wdog_limit       (wdog_limit),
    .wdog_clr         (wdog_clr),
    .wdog_expired     (wdog_expired),
    .frame_done       (frame_done),
    .frame_done_tid   (frame_done_tid),
    .frame_done_beats (frame_done_beats)
  );

  always #5 clk = ~clk;

  // Output monitor: records m-side handshakes and frame_done pulses, watches stall stability.
  logic [1:0]  o_tid   [512];
  logic [63:0] o_data  [512];
  logic [7:0]  o_user  [512];
  logic        o_last  [512];
  logic        o_stats [512];
  logic [15:0] o_beats [512];
  int          out_n = 0;
  logic [1:0]  fd_tid   [64];
  logic [15:0] fd_beats [64];
  int          fd_n = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [1:0]  prev_tid;
  logic [7:0]  prev_user;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tid !== prev_tid ||
                         m_tuser !== prev_user)) begin
        stall_viol <= stall_viol + 1;
      end
      prev_stall <= m_tvalid && !m_tready;
      prev_data  <= m_tdata;
      prev_tid   <= m_tid;
      prev_user  <= m_tuser;
      if (m_tvalid && m_tready && out_n < 512) begin
        o_tid[out_n]   <= m_tid;
        o_data[out_n]  <= m_tdata;
        o_user[out_n]  <= m_tuser;
        o_last[out_n]  <= m_tlast;
        o_stats[out_n] <= m_tstats;
        o_beats[out_n] <= m_tbeats;
        out_n          <= out_n + 1;
      end
      if (frame_done && fd_n < 64) begin
        fd_tid[fd_n]   <= frame_done_tid;
        fd_beats[fd_n] <= frame_done_beats;
        fd_n           <= fd_n + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] tid, input logic [63:0] data, input logic [7:0] user);
    bit done = 1'b0;
    int n = 0;
    s_tid    = tid;
    s_tdata  = data;
    s_tstrb  = 8'hff;
    s_tuser  = user;
    s_tvalid = 1'b1;
    while (!done) begin
      if (rnd_rdy) m_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = s_tready;
      tick();
      n++;
      if (!done && n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: tid=%0d not accepted after %0d cycles, want accept", tid, n);
        done = 1'b1;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++; $display("FAIL reset_tvalid: got %0b want 0", m_tvalid);
    end
    total++;
    if (s_tready !== 1'b1) begin
      bad++; $display("FAIL reset_tready: got %0b want 1", s_tready);
    end
    total++;
    if (m_tlast !== 1'b0 || m_tstats !== 1'b0) begin
      bad++; $display("FAIL reset_tags: got last=%0b stats=%0b want 0 0", m_tlast, m_tstats);
    end
    total++;
    if (m_tdata !== 64'h0 || m_tbeats !== 16'h0 || m_tuser !== 8'h0) begin
      bad++;
      $display("FAIL reset_payload: got data=%h beats=%0d user=%0d want 0 0 0",
               m_tdata, m_tbeats, m_tuser);
    end
    total++;
    if (frame_done !== 1'b0 || frame_done_beats !== 16'h0 || wdog_expired !== 1'b0) begin
      bad++;
      $display("FAIL reset_status: got fd=%0b fd_beats=%0d wdog=%0b want 0 0 0",
               frame_done, frame_done_beats, wdog_expired);
    end
  endtask

  task automatic test_cqe_frame();
    int base = out_n;
    int fbase = fd_n;
    logic [7:0]  exp_user  [4] = '{8'd1, 8'd0, 8'd0, 8'd2};
    logic        exp_last  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] exp_beats [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    logic [63:0] exp_data  [4] = '{64'h1111_0000_0000_0009, 64'hA0A0, 64'hB0B0, 64'hC0C0};
    send(2'd0, 64'h1111_0000_0000_0009, 8'd1);
    send(2'd0, 64'hA0A0, 8'd3);
    send(2'd0, 64'hB0B0, 8'd3);
    send(2'd0, 64'hC0C0, 8'd2);
    drain();
    total++;
    if (out_n - base !== 4) begin
      bad++; $display("FAIL cqe_count: got %0d beats want 4", out_n - base);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (o_user[base+i] !== exp_user[i] || o_last[base+i] !== exp_last[i] ||
          o_beats[base+i] !== exp_beats[i] || o_stats[base+i] !== 1'b0 ||
          o_data[base+i] !== exp_data[i] || o_tid[base+i] !== 2'd0) begin
        bad++;
        $display("FAIL cqe_beat%0d: got user=%0d last=%0b beats=%0d stats=%0b data=%h want %0d %0b %0d 0 %h",
                 i, o_user[base+i], o_last[base+i], o_beats[base+i], o_stats[base+i],
                 o_data[base+i], exp_user[i], exp_last[i], exp_beats[i], exp_data[i]);
      end
    end
    total++;
    if (fd_n - fbase !== 1 || fd_tid[fbase] !== 2'd0 || fd_beats[fbase] !== 16'd4) begin
      bad++;
      $display("FAIL cqe_done: got n=%0d tid=%0d beats=%0d want 1 0 4",
               fd_n - fbase, fd_tid[fbase], fd_beats[fbase]);
    end
    total++;
    if (frame_done !== 1'b0) begin
      bad++; $display("FAIL cqe_done_pulse: got %0b after pulse want 0", frame_done);
    end
  endtask

  task automatic test_interleave();
    int base = out_n;
    int fbase = fd_n;
    logic [1:0]  exp_tid   [5] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd2};
    logic [7:0]  exp_user  [5] = '{8'd1, 8'd1, 8'd0, 8'd2, 8'd2};
    logic        exp_last  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        exp_stats [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_beats [5] = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd3};
    send(2'd1, 64'h0000_0000_0000_0108, 8'd1);
    send(2'd2, 64'h0000_0000_0000_0209, 8'd1);
    send(2'd2, 64'h2222, 8'd3);
    send(2'd1, 64'h1111, 8'd2);
    send(2'd2, 64'h2223, 8'd2);
    drain();
    total++;
    if (out_n - base !== 5) begin
      bad++; $display("FAIL ilv_count: got %0d beats want 5", out_n - base);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (o_tid[base+i] !== exp_tid[i] || o_user[base+i] !== exp_user[i] ||
          o_last[base+i] !== exp_last[i] || o_stats[base+i] !== exp_stats[i] ||
          o_beats[base+i] !== exp_beats[i]) begin
        bad++;
        $display("FAIL ilv_beat%0d: got tid=%0d user=%0d last=%0b stats=%0b beats=%0d want %0d %0d %0b %0b %0d",
                 i, o_tid[base+i], o_user[base+i], o_last[base+i], o_stats[base+i],
                 o_beats[base+i], exp_tid[i], exp_user[i], exp_last[i], exp_stats[i],
                 exp_beats[i]);
      end
    end
    total++;
    if (fd_n - fbase !== 1 || fd_tid[fbase] !== 2'd2 || fd_beats[fbase] !== 16'd3) begin
      bad++;
      $display("FAIL ilv_done: got n=%0d tid=%0d beats=%0d want 1 2 3",
               fd_n - fbase, fd_tid[fbase], fd_beats[fbase]);
    end
  endtask

  task automatic test_orphan_trailer();
    int base = out_n;
    int fbase = fd_n;
    logic        exp_last  [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] exp_beats [3] = '{16'd1, 16'd2, 16'd3};
    send(2'd3, 64'h3330, 8'd2);
    send(2'd3, 64'h0000_0000_0000_0309, 8'd1);
    send(2'd3, 64'h3332, 8'd2);
    drain();
    total++;
    if (out_n - base !== 3) begin
      bad++; $display("FAIL orphan_count: got %0d beats want 3", out_n - base);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (o_last[base+i] !== exp_last[i] || o_stats[base+i] !== 1'b0 ||
          o_beats[base+i] !== exp_beats[i] || o_tid[base+i] !== 2'd3) begin
        bad++;
        $display("FAIL orphan_beat%0d: got last=%0b stats=%0b beats=%0d tid=%0d want %0b 0 %0d 3",
                 i, o_last[base+i], o_stats[base+i], o_beats[base+i], o_tid[base+i],
                 exp_last[i], exp_beats[i]);
      end
    end
    total++;
    if (fd_n - fbase !== 1 || fd_tid[fbase] !== 2'd3 || fd_beats[fbase] !== 16'd3) begin
      bad++;
      $display("FAIL orphan_done: got n=%0d tid=%0d beats=%0d want 1 3 3",
               fd_n - fbase, fd_tid[fbase], fd_beats[fbase]);
    end
  endtask

  task automatic test_stream();
    int base = out_n;
    int viol0 = stall_viol;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [7:0] u;
      case (i % 3)
        0:       u = 8'd3;
        1:       u = 8'd0;
        default: u = 8'd5;
      endcase
      send(2'(i % 4), {16'hCAFE, 16'(i), 32'(i * 7)}, u);
    end
    rnd_rdy = 1'b0;
    drain();
    total++;
    if (out_n - base !== 100) begin
      bad++; $display("FAIL stream_count: got %0d beats want 100", out_n - base);
    end
    for (int i = 0; i < 100; i++) begin
      logic [7:0]  eu;
      logic [63:0] ed;
      eu = ((i % 3) == 2) ? 8'd5 : 8'd0;
      ed = {16'hCAFE, 16'(i), 32'(i * 7)};
      total++;
      if (o_data[base+i] !== ed || o_tid[base+i] !== 2'(i % 4) || o_user[base+i] !== eu ||
          o_last[base+i] !== 1'b0) begin
        bad++;
        $display("FAIL stream_beat%0d: got data=%h tid=%0d user=%0d last=%0b want %h %0d %0d 0",
                 i, o_data[base+i], o_tid[base+i], o_user[base+i], o_last[base+i], ed,
                 i % 4, eu);
      end
    end
    total++;
    if (stall_viol - viol0 !== 0) begin
      bad++; $display("FAIL stream_stall_stable: got %0d violations want 0", stall_viol - viol0);
    end
  endtask

  task automatic test_watchdog();
    m_tready   = 1'b1;
    wdog_limit = 16'd10;
    wdog_en    = 1'b0;
    tick();
    wdog_en = 1'b1;
    repeat (9) tick();
    total++;
    if (wdog_expired !== 1'b0) begin
      bad++; $display("FAIL wdog_early: got %0b after 9 cycles want 0", wdog_expired);
    end
    tick();
    total++;
    if (wdog_expired !== 1'b1) begin
      bad++; $display("FAIL wdog_expire: got %0b after 10 cycles want 1", wdog_expired);
    end
    wdog_clr = 1'b1;
    tick();
    total++;
    if (wdog_expired !== 1'b0) begin
      bad++; $display("FAIL wdog_clr: got %0b want 0", wdog_expired);
    end
    wdog_clr   = 1'b0;
    wdog_limit = 16'd0;
    repeat (30) tick();
    total++;
    if (wdog_expired !== 1'b0) begin
      bad++; $display("FAIL wdog_limit0: got %0b want 0", wdog_expired);
    end
    wdog_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    int base;
    m_tready = 1'b0;
    send(2'd0, 64'h0000_0000_0000_0009, 8'd1);
    total++;
    if (m_tvalid !== 1'b1) begin
      bad++; $display("FAIL midrst_held: got tvalid=%0b want 1", m_tvalid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state: got tvalid=%0b tready=%0b fd=%0b want 0 1 0",
               m_tvalid, s_tready, frame_done);
    end
    m_tready = 1'b1;
    base = out_n;
    send(2'd0, 64'h5555, 8'd2);
    drain();
    total++;
    if (out_n - base !== 1 || o_last[base] !== 1'b0 || o_stats[base] !== 1'b0 ||
        o_beats[base] !== 16'd1 || o_user[base] !== 8'd2) begin
      bad++;
      $display("FAIL midrst_trailer: got n=%0d last=%0b stats=%0b beats=%0d user=%0d want 1 0 0 1 2",
               out_n - base, o_last[base], o_stats[base], o_beats[base], o_user[base]);
    end
  endtask

  initial begin
    test_reset();
    test_cqe_frame();
    test_interleave();
    test_orphan_trailer();
    test_stream();
    test_watchdog();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
